// File: rtl/hazard_controller.sv
// Hazard detection, stall/flush control, operand forwarding selects and the
// multiply/divide busy sequencer for the 5-stage MIPS pipeline.
module hazard_controller #(
   parameter int MDU_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       JumpD,
   input  logic       PCSrcD,
   input  logic       MduStartD,
   input  logic       MduStartE,
   input  logic       MfhiloD,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MduBusy,
   output logic       MduDone
);

   localparam int CW = $clog2(MDU_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_busy;
   logic            w_done;
   logic            w_lwstall;
   logic            w_brstall;
   logic            w_mdustall;
   logic            w_stall;
   logic [1:0]      w_fae;
   logic [1:0]      w_fbe;
   logic            w_fad;
   logic            w_fbd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A start arriving while BUSY cannot happen (mdustall holds it in D) and is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (MduStartE) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = CW'(MDU_CYCLES - 1);
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) w_state_nxt = S_DONE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         S_DONE: begin
            if (MduStartE) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = CW'(MDU_CYCLES - 1);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state == S_BUSY);
      w_done = (r_state == S_DONE);
   end

   always_comb begin
      w_fae = 2'b00;
      if (RsE != 5'd0 && RsE == WriteRegM && RegWriteM)      w_fae = 2'b10;
      else if (RsE != 5'd0 && RsE == WriteRegW && RegWriteW) w_fae = 2'b01;
      w_fbe = 2'b00;
      if (RtE != 5'd0 && RtE == WriteRegM && RegWriteM)      w_fbe = 2'b10;
      else if (RtE != 5'd0 && RtE == WriteRegW && RegWriteW) w_fbe = 2'b01;
      w_fad = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
      w_fbd = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;

      w_lwstall  = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
      w_brstall  = BranchD &&
                   ((RegWriteE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != 5'd0) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD))));
      w_mdustall = (MfhiloD || MduStartD) && (MduStartE || w_busy);
      w_stall    = w_lwstall || w_brstall || w_mdustall;
   end

   // During reset the pipeline drains: front end runs, both buffers clear.
   always_comb begin
      if (rst) begin
         StallF    = 1'b0;
         StallD    = 1'b0;
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         ForwardAD = 1'b0;
         ForwardBD = 1'b0;
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
         MduBusy   = 1'b0;
         MduDone   = 1'b0;
      end else begin
         StallF    = w_stall;
         StallD    = w_stall;
         FlushD    = (PCSrcD || JumpD) && !w_stall;
         FlushE    = w_stall;
         ForwardAD = w_fad;
         ForwardBD = w_fbd;
         ForwardAE = w_fae;
         ForwardBE = w_fbe;
         MduBusy   = w_busy;
         MduDone   = w_done;
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: expected output vectors are queued as
// stimulus is applied and compared once per cycle at the falling clock edge.
module tb_hazard_controller;

   logic       clk;
   logic       rst;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic       BranchD, JumpD, PCSrcD, MduStartD, MduStartE, MfhiloD;
   logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
   logic       MduBusy, MduDone;

   typedef struct {
      string       tag;
      logic [12:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          failures;
   logic [12:0] obs;

   hazard_controller #(.MDU_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
      .MduStartD(MduStartD), .MduStartE(MduStartE), .MfhiloD(MfhiloD),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MduBusy(MduBusy), .MduDone(MduDone)
   );

   assign obs = {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
                 ForwardAE, ForwardBE, MduBusy, MduDone};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   function automatic logic [12:0] mk(input bit stall, input bit fd, input bit fe,
                                      input bit fad, input bit fbd,
                                      input logic [1:0] fae, input logic [1:0] fbe,
                                      input bit busy, input bit done);
      return {stall, stall, fd, fe, fad, fbd, fae, fbe, busy, done};
   endfunction

   task automatic push(input string tag, input logic [12:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check();
      exp_t x;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty obs=%b exp=<none>", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; JumpD = 0; PCSrcD = 0;
      MduStartD = 0; MduStartE = 0; MfhiloD = 0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      clr();
      // reset forces outputs even with hazard/forward conditions present
      rst = 1;
      RsE = 5; WriteRegM = 5; RegWriteM = 1;
      MemtoRegE = 1; RtE = 8; RsD = 8;
      push("reset_outputs", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      check();

      tick(); rst = 0; clr();
      RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
      push("fwd_ae_m", mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
      check();
      tick(); RegWriteM = 0;
      push("fwd_ae_w", mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      check();
      tick(); RsE = 0;
      push("fwd_ae_r0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); RtE = 7; WriteRegM = 7; RegWriteM = 1; WriteRegW = 7; RegWriteW = 1;
      push("fwd_be_m", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0));
      check();

      // load-use: one stall cycle, then the bubble, then W forwarding
      tick(); clr(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtE = 8; RsD = 8;
      push("lw_stall", mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); RsD = 8; WriteRegM = 8; RegWriteM = 1; MemtoRegM = 1;
      push("lw_release", mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); RsE = 8; WriteRegW = 8; RegWriteW = 1;
      push("lw_fwd_w", mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      check();
      tick(); clr(); MemtoRegE = 1; RtE = 9; RtD = 9;
      push("lw_stall_rt", mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); MemtoRegE = 1; RtE = 0; RsD = 0;
      push("lw_r0_nostall", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      check();

      // branch: stall hides the taken flush, then forwards from M
      tick(); clr(); BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
      push("br_stall", mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); RegWriteE = 0; WriteRegE = 0; WriteRegM = 3; RegWriteM = 1;
      push("br_taken", mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); BranchD = 1; RtD = 4; MemtoRegM = 1; WriteRegM = 4; RegWriteM = 1; JumpD = 1;
      push("br_load_m", mk(1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; MemtoRegE = 1; RtE = 3;
      push("lw_and_br", mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      check();
      tick(); clr(); JumpD = 1;
      push("jump_flush", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      check();

      // MDU op with dependent mfhi waiting in D
      tick(); clr(); MduStartE = 1; MfhiloD = 1;
      push("mdu_t0", mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      for (int k = 1; k <= 4; k++) push("mdu_busy", mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0));
      push("mdu_done", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      push("mdu_idle", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      check();
      for (int k = 1; k <= 5; k++) begin
         tick(); MduStartE = 0;
         check();
      end
      tick(); MfhiloD = 0;
      check();

      // back-to-back ops, second start in the DONE cycle
      tick(); clr();
      push("b2b_t0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      for (int k = 1; k <= 11; k++) begin
         push("b2b_seq", mk(k == 7, 0, k == 7, 0, 0, 2'b00, 2'b00,
                            (k >= 1 && k <= 4) || (k >= 6 && k <= 9),
                            (k == 5) || (k == 10)));
      end
      for (int k = 0; k <= 11; k++) begin
         if (k > 0) tick();
         MduStartE = (k == 0) || (k == 5);
         MduStartD = (k == 7);
         check();
      end

      // reset in the second BUSY cycle aborts the op
      tick(); clr();
      push("rst_mdu_t0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      push("rst_mdu_busy", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
      push("rst_mdu_forced", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      for (int k = 3; k <= 8; k++) push("rst_mdu_idle", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) tick();
         rst       = (k == 2);
         MduStartE = (k == 0);
         MfhiloD   = (k == 2);
         check();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage 32-bit MIPS core. It detects load-use, branch-operand and multi-cycle multiply/divide (MDU) hazards, and drives the stall enables of the IF and IF/ID stages. It drives the CLR input of the ID/EX buffer and the flush of IF/ID, and generates the forwarding selects for the D-stage branch comparator and the E-stage ALU. It also owns the MDU busy sequencer that times HI/LO availability.

## Interface
Parameters:
- MDU_CYCLES, 32, number of busy cycles of a mult/div operation (legal range ≥1)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- RsD, RtD  in  5 each  source registers of instruction in D
- RsE, RtE  in  5 each  source registers of instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enable in E/M/W
- MemtoRegE, MemtoRegM  in  1 each  instruction in E/M is a load
- BranchD  in  1  instruction in D is a conditional branch
- JumpD  in  1  instruction in D is a jump
- PCSrcD  in  1  branch in D resolved taken
- MduStartD, MduStartE  in  1 each  mult/div instruction in D / E
- MfhiloD  in  1  instruction in D reads HI or LO
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID buffer
- FlushD  out  1  clear IF/ID buffer
- FlushE  out  1  to ID/EX buffer CLR (inserts bubble)
- ForwardAD, ForwardBD  out  1 each  branch comparator operand from ALUOutM
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 ResultW, 10 ALUOutM
- MduBusy  out  1  MDU sequencer in BUSY
- MduDone  out  1  one-cycle HI/LO write strobe

## Operation
- Forwarding (combinational): ForwardAE=10 if RsE≠0 & RsE==WriteRegM & RegWriteM; else 01 if RsE≠0 & RsE==WriteRegW & RegWriteW; else 00. M has priority over W. ForwardBE is the same using RtE. ForwardAD=RsD≠0 & RsD==WriteRegM & RegWriteM; ForwardBD is the same using RtD.
- lwstall = MemtoRegE & RtE≠0 & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & WriteRegM≠0 & (WriteRegM==RsD | WriteRegM==RtD))).
- mdustall = (MfhiloD | MduStartD) & (MduStartE | state==BUSY).
- stall = lwstall | brstall | mdustall. StallF = StallD = FlushE = stall.
- FlushD = (PCSrcD | JumpD) & ~stall. A stalled branch never flushes, because its operands are stale.
- MDU FSM states are IDLE, BUSY and DONE, with counter cnt of width clog2(MDU_CYCLES)+1:
  - IDLE: MduStartE moves to BUSY and sets cnt=MDU_CYCLES-1.
  - BUSY: if cnt==0 move to DONE, else cnt decrements.
  - DONE: MduStartE moves to BUSY and reloads cnt (back-to-back op); otherwise move to IDLE.
  - MduStartE while in BUSY is illegal (prevented by mdustall) and is ignored.
- MduBusy = (state==BUSY). MduDone = (state==DONE).

## Timing
- Reset (rst high at an edge): state=IDLE, cnt=0.
- While rst is high, the outputs are forced as follows:
  - StallF=StallD=0 and FlushD=FlushE=1, so the pipeline drains with bubbles.
  - Forward*=0 and MduBusy=MduDone=0.
- Reset mid-BUSY aborts the operation, and no MduDone is produced.
- All hazard and forward outputs are combinational, with zero latency from their inputs.
- MDU timing for MduStartE high in cycle t:
  - MduBusy is high for cycles t+1 … t+MDU_CYCLES.
  - MduDone is high in cycle t+MDU_CYCLES+1 only.
  - MDU_CYCLES=1 gives one BUSY cycle.
- A MfhiloD waiting on the MDU is stalled in cycle t and in every BUSY cycle. It is released in the DONE cycle, enters E at the following edge, and sees the updated HI/LO.
- Simultaneous lwstall and brstall produce a single stall with the same outputs; there is no double counting.
- A stall together with PCSrcD|JumpD gives FlushD=0 and FlushE=1.

## Test plan
- Forwarding from M:
  - Stimulus: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1.
  - Required: ForwardAE=10.
  - Then drop RegWriteM: ForwardAE=01. Then set RsE=0: ForwardAE=00.
- Load-use stall:
  - Stimulus: MemtoRegE=1, RtE=8, RsD=8.
  - Required: StallF=StallD=FlushE=1 for exactly one cycle. When the load advances (MemtoRegE=0), the stalls drop and ForwardAE=01 on the next E.
- Branch stall, then taken:
  - Stimulus: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3, PCSrcD=1.
  - Required: stall=1 and FlushD=0.
  - Next cycle, with the producer in M: ForwardAD=1, stall=0, FlushD=1.
- MDU sequencing with MDU_CYCLES=4:
  - Stimulus: MduStartE at t, MfhiloD held high from t.
  - Required: MduBusy high for t+1…t+4; MduDone high only at t+5; stall high for t…t+4; stall low at t+5.
- Back-to-back MDU ops: a second MduStartE in the DONE cycle returns the FSM to BUSY for 4 cycles, with MduDone exactly once per op.
- Reset mid-BUSY:
  - Stimulus: rst high for one cycle at the second BUSY cycle.
  - Required: state is IDLE next cycle; MduDone is never asserted; FlushE=1 and StallF=0 during reset.
